// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory load/store with configurable latency.
// Optional macro MISALIGN_TRAP_EN: trap misaligned word/half accesses instead of masking address bits.
module mem_access_stage #(
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] WriteData_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic [4:0]  WriteReg_in,
  output logic        Stall,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUResult_out,
  output logic [4:0]  WriteReg_out,
  output logic        MisalignedErr
);

  localparam int         AW       = $clog2(MEM_DEPTH);
  localparam bit         HAS_WAIT = (LATENCY != 0);
  localparam logic [3:0] LAT_M1   = 4'(LATENCY - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t        state_r, state_next_s;
  logic [3:0]    cnt_r, cnt_next_s;
  logic [31:0]   mem_r [MEM_DEPTH];
  logic          req_s, stall_s, done_s, trap_s, wr_en_s, rd_en_s;
  logic [AW-1:0] widx_s;
  logic [1:0]    off_s;
  logic [31:0]   rword_s, load_s, merged_s;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'b01:   load_extract = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
      2'b10:   load_extract = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h000000, sh[7:0]};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] off, input logic [1:0] size);
    logic [31:0] mask, data;
    case (size)
      2'b01: begin
        mask = 32'h0000_FFFF << {off[1], 4'b0000};
        data = {16'h0000, wdata[15:0]} << {off[1], 4'b0000};
      end
      2'b10: begin
        mask = 32'h0000_00FF << {off, 3'b000};
        data = {24'h000000, wdata[7:0]} << {off, 3'b000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wdata;
      end
    endcase
    store_merge = (old & ~mask) | (data & mask);
  endfunction

  // Address decode: word index wraps modulo memory size, low bits masked per access size
  always_comb begin
    req_s  = MemRead | MemWrite;
    widx_s = ALUResult_in[AW+1:2];
    case (MemSize)
      2'b01:   off_s = {ALUResult_in[1], 1'b0};
      2'b10:   off_s = ALUResult_in[1:0];
      default: off_s = 2'b00;
    endcase
`ifdef MISALIGN_TRAP_EN
    case (MemSize)
      2'b01:   trap_s = req_s & ALUResult_in[0];
      2'b10:   trap_s = 1'b0;
      default: trap_s = req_s & (|ALUResult_in[1:0]);
    endcase
`else
    trap_s = 1'b0;
`endif
    rword_s  = mem_r[widx_s];
    load_s   = load_extract(rword_s, off_s, MemSize, MemSigned);
    merged_s = store_merge(rword_s, WriteData_in, off_s, MemSize);
  end

  // Next-state logic; a trapped access completes immediately without waiting
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    stall_s      = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s && !trap_s && HAS_WAIT) begin
          stall_s      = 1'b1;
          state_next_s = ST_WAIT;
          cnt_next_s   = LAT_M1;
        end else begin
          done_s = req_s;
        end
      end
      ST_WAIT: begin
        if (cnt_r != 4'd0) begin
          stall_s    = 1'b1;
          cnt_next_s = cnt_r - 4'd1;
        end else begin
          done_s       = req_s;
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
    wr_en_s = done_s & MemWrite & ~trap_s;
    rd_en_s = done_s & MemRead & ~MemWrite & ~trap_s;
  end

  assign Stall = stall_s & ~Reset;

  // State register and wait counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Data memory; contents survive reset and an aborted access never writes
  always_ff @(posedge Clk) begin
    if (!Reset && wr_en_s) begin
      mem_r[widx_s] <= merged_s;
    end
  end

  // MEM/WB register; a stalled cycle inserts a bubble so WB never repeats a write
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RegWrite_out  <= 1'b0;
      MemToReg_out  <= 1'b0;
      ReadData_out  <= 32'h0000_0000;
      ALUResult_out <= 32'h0000_0000;
      WriteReg_out  <= 5'd0;
      MisalignedErr <= 1'b0;
    end else if (stall_s) begin
      RegWrite_out  <= 1'b0;
      MemToReg_out  <= 1'b0;
      MisalignedErr <= 1'b0;
    end else begin
      RegWrite_out  <= RegWrite_in & ~trap_s;
      MemToReg_out  <= MemToReg_in;
      ReadData_out  <= rd_en_s ? load_s : 32'h0000_0000;
      ALUResult_out <= ALUResult_in;
      WriteReg_out  <= WriteReg_in;
      MisalignedErr <= trap_s;
    end
  end

endmodule
